updn_counter_gen: RTL

//  Parametrised up/down counter: successor to the fixed 8-bit counter.

---
 rtl/counter_pkg.sv | 24 ++
 rtl/counter_prescaler.sv | 28 ++
 rtl/updn_counter_gen.sv | 122 ++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and helpers for the up/down counter
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Encoding 11 is treated as WRAP.
    function automatic mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   decode_mode = MODE_SAT;
            2'b10:   decode_mode = MODE_ONESHOT;
            default: decode_mode = MODE_WRAP;
        endcase
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - clock-enable prescaler, one tick per prescale+1 enabled cycles
module counter_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] count;

    // >= rather than == so a prescale lowered below the current phase ticks at once.
    assign tick = enable && (count >= prescale);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/updn_counter_gen.sv
// rtl/updn_counter_gen.sv - parametrised up/down counter with limit, step, modes and prescaler
module updn_counter_gen
    import counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PL_WIDTH   = 4,
    parameter int STEP_WIDTH = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  updn,
    input  logic                  preload,
    input  logic [PL_WIDTH-1:0]   pl_data,
    input  logic [STEP_WIDTH-1:0] step,
    input  logic [WIDTH-1:0]      limit,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      cout,
    output logic                  tc,
    output logic                  running
);

    state_t state, state_next;
    logic [WIDTH-1:0] cout_next;
    logic             tc_next;
    logic             tick;
    mode_t            cur_mode;

    logic [WIDTH-1:0] pl_ext;
    logic [WIDTH:0]   cur_x, lim_x, lim1_x, step_x;
    logic [WIDTH:0]   sum_x, diff_x, down_wrap_x, up_wrap_x;

    counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .clear    (preload),
        .prescale (prescale),
        .tick     (tick)
    );

    assign cur_mode = decode_mode(mode);
    assign pl_ext   = WIDTH'(pl_data);

    // All arithmetic is one bit wider so overflow past limit is visible.
    assign cur_x       = {1'b0, cout};
    assign lim_x       = {1'b0, limit};
    assign lim1_x      = lim_x + 1'b1;
    assign step_x      = (WIDTH+1)'(step);
    assign sum_x       = cur_x + step_x;
    assign diff_x      = cur_x - step_x;
    assign up_wrap_x   = sum_x - lim1_x;
    assign down_wrap_x = cur_x + lim1_x - step_x;

    always_comb begin
        cout_next  = cout;
        tc_next    = 1'b0;
        state_next = state;
        if (preload) begin
            cout_next  = (pl_ext > limit) ? limit : pl_ext;
            state_next = ST_RUN;
        end else if (tick && state == ST_RUN) begin
            if (cur_x > lim_x) begin
                cout_next = limit;
                tc_next   = 1'b1;
            end else if (step != '0) begin
                if (updn) begin
                    if (sum_x > lim_x) begin
                        if (cur_mode == MODE_WRAP) begin
                            cout_next = up_wrap_x[WIDTH-1:0];
                            tc_next   = 1'b1;
                        end else begin
                            cout_next = limit;
                            tc_next   = (cout != limit);
                            if (cur_mode == MODE_ONESHOT) state_next = ST_DONE;
                        end
                    end else begin
                        cout_next = sum_x[WIDTH-1:0];
                        if (cur_mode != MODE_WRAP && sum_x == lim_x) begin
                            tc_next = 1'b1;
                            if (cur_mode == MODE_ONESHOT) state_next = ST_DONE;
                        end
                    end
                end else begin
                    if (step_x > cur_x) begin
                        if (cur_mode == MODE_WRAP) begin
                            cout_next = down_wrap_x[WIDTH-1:0];
                            tc_next   = 1'b1;
                        end else begin
                            cout_next = '0;
                            tc_next   = (cout != '0);
                            if (cur_mode == MODE_ONESHOT) state_next = ST_DONE;
                        end
                    end else begin
                        cout_next = diff_x[WIDTH-1:0];
                        if (cur_mode != MODE_WRAP && diff_x == '0) begin
                            tc_next = 1'b1;
                            if (cur_mode == MODE_ONESHOT) state_next = ST_DONE;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cout  <= '0;
            tc    <= 1'b0;
            state <= ST_RUN;
        end else begin
            cout  <= cout_next;
            tc    <= tc_next;
            state <= state_next;
        end
    end

    assign running = (state == ST_RUN);

endmodule
